// File: rtl/custom_logic_pkg.sv
// rtl/custom_logic_pkg.sv - shared source encoding and helpers for the rr merge
package custom_logic_pkg;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  localparam src_e LAST_RST = SRC_B;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/custom_logic_pipe_reg.sv
// rtl/custom_logic_pipe_reg.sv - one-entry valid/ready output slice
module custom_logic_pipe_reg #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // Accept when empty or when the held beat drains on this same edge.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/custom_logic_rr_merge.sv
// rtl/custom_logic_rr_merge.sv - two-input round-robin merge; CUSTOM_LOGIC_RR_MERGE_BURST_EN enables burst priority
module custom_logic_rr_merge
  import custom_logic_pkg::*;
#(
  parameter int D_WIDTH   = 6,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   up_data_a,
  input  logic                 up_valid_a,
  output logic                 up_ready_a,
  input  logic [D_WIDTH-1:0]   up_data_b,
  input  logic                 up_valid_b,
  output logic                 up_ready_b,
  output logic [D_WIDTH-1:0]   down_data,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic                 down_src,
  output logic [CNT_WIDTH-1:0] beat_cnt_a,
  output logic [CNT_WIDTH-1:0] beat_cnt_b
);

  src_e               last;
  src_e               prio;
  src_e               grant;
  logic               can_load;
  logic               xfer;
  logic [D_WIDTH:0]   slice_in;
  logic [D_WIDTH:0]   slice_out;

`ifdef CUSTOM_LOGIC_RR_MERGE_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

  logic [BW-1:0] burst_cnt;

  // burst_cnt is zero only straight out of reset, where there is no owner yet.
  always_comb begin
    prio = other_src(last);
    if (burst_cnt != '0 && burst_cnt < BURST_MAX) prio = last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (xfer) begin
      if (grant != last)             burst_cnt <= BW'(1);
      else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  logic unused_burst_len;
  assign unused_burst_len = (BURST_LEN > 0);

  always_comb begin
    prio = other_src(last);
  end
`endif

  always_comb begin
    grant = prio;
    if (up_valid_a && !up_valid_b)      grant = SRC_A;
    else if (!up_valid_a && up_valid_b) grant = SRC_B;
  end

  assign up_ready_a = !rst && can_load && up_valid_a && (grant == SRC_A);
  assign up_ready_b = !rst && can_load && up_valid_b && (grant == SRC_B);
  assign xfer       = up_ready_a || up_ready_b;

  assign slice_in = (grant == SRC_B) ? {up_data_b, 1'b1} : {up_data_a, 1'b0};

  custom_logic_pipe_reg #(
    .WIDTH(D_WIDTH + 1)
  ) u_out_slice (
    .clk      (clk),
    .rst      (rst),
    .in_data  (slice_in),
    .in_valid (xfer),
    .in_ready (can_load),
    .out_data (slice_out),
    .out_valid(down_valid),
    .out_ready(down_ready)
  );

  assign down_data = slice_out[D_WIDTH:1];
  assign down_src  = slice_out[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= LAST_RST;
      beat_cnt_a <= '0;
      beat_cnt_b <= '0;
    end else begin
      if (xfer)       last       <= grant;
      if (up_ready_a) beat_cnt_a <= beat_cnt_a + 1'b1;
      if (up_ready_b) beat_cnt_b <= beat_cnt_b + 1'b1;
    end
  end

endmodule

// File: tb/tb_custom_logic_rr_merge.sv
// tb/tb_custom_logic_rr_merge.sv - randomized and directed bench for custom_logic_rr_merge
module tb_custom_logic_rr_merge;

  localparam int DW = 6;
  localparam int BL = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] up_data_a, up_data_b, down_data;
  logic          up_valid_a, up_valid_b, up_ready_a, up_ready_b;
  logic          down_valid, down_ready, down_src;
  logic [CW-1:0] beat_cnt_a, beat_cnt_b;

  always #5 clk = ~clk;

  custom_logic_rr_merge #(.D_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .up_data_a(up_data_a), .up_valid_a(up_valid_a), .up_ready_a(up_ready_a),
    .up_data_b(up_data_b), .up_valid_b(up_valid_b), .up_ready_b(up_ready_b),
    .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
    .down_src(down_src), .beat_cnt_a(beat_cnt_a), .beat_cnt_b(beat_cnt_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: last winner, length of its current run, held beat, totals.
  bit          m_v, m_s, m_last;
  logic [DW-1:0] m_d;
  int          m_run, m_ca, m_cb;

  function automatic bit m_prio();
`ifdef CUSTOM_LOGIC_RR_MERGE_BURST_EN
    return (m_run > 0 && m_run < BL) ? m_last : !m_last;
`else
    return !m_last;
`endif
  endfunction

  task automatic m_reset();
    m_v = 0; m_s = 0; m_d = '0; m_last = 1; m_run = 0; m_ca = 0; m_cb = 0;
  endtask

  logic          o_ra, o_rb, o_dv, o_ds;
  logic [DW-1:0] o_dd;
  logic [CW-1:0] o_ca, o_cb;
  bit            x_a, x_b;

  task automatic step(input bit r, input bit va, input logic [DW-1:0] da,
                      input bit vb, input logic [DW-1:0] db, input bit dr);
    bit cl, g, ea, eb;
    @(negedge clk);
    rst = r; up_valid_a = va; up_data_a = da; up_valid_b = vb; up_data_b = db; down_ready = dr;
    #1;
    cl = !m_v || dr;
    g  = (va && vb) ? m_prio() : vb;
    ea = !r && cl && va && !g;
    eb = !r && cl && vb && g;
    o_ra = up_ready_a; o_rb = up_ready_b; o_dv = down_valid; o_dd = down_data;
    o_ds = down_src; o_ca = beat_cnt_a; o_cb = beat_cnt_b;
    chk("up_ready_a", o_ra, ea);
    chk("up_ready_b", o_rb, eb);
    chk("down_valid", o_dv, m_v);
    if (m_v) begin
      chk("down_data", o_dd, m_d);
      chk("down_src", o_ds, m_s);
    end
    chk("beat_cnt_a", o_ca, m_ca % (1 << CW));
    chk("beat_cnt_b", o_cb, m_cb % (1 << CW));
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (ea || eb) begin
      m_v = 1; m_s = g; m_d = g ? db : da;
      m_run = (g == m_last) ? m_run + 1 : 1;
      m_last = g;
      if (g) m_cb++; else m_ca++;
    end else if (dr) begin
      m_v = 0;
    end
    x_a = ea; x_b = eb;
  endtask

  initial begin
    bit va, vb, dr;
    logic [DW-1:0] da, db;
    int exp_src;

    rst = 1; up_valid_a = 0; up_valid_b = 0; up_data_a = '0; up_data_b = '0; down_ready = 0;
    m_reset();
    repeat (2) @(posedge clk);

    // First beat after reset release goes to A with no extra latency.
    step(1, 1, 6'h05, 1, 6'h2A, 1);
    chk("rst_ready_a", o_ra, 0);
    chk("rst_down_valid", o_dv, 0);
    chk("rst_down_data", o_dd, 0);
    chk("rst_down_src", o_ds, 0);
    step(0, 1, 6'h05, 1, 6'h2A, 1);
    step(0, 1, 6'h05, 1, 6'h2A, 1);
    chk("first_valid", o_dv, 1);
    chk("first_data", o_dd, 6'h05);
    chk("first_src", o_ds, 0);

    // Continuous contention: source order pattern and per-side totals.
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 6'h11, 1, 6'h22, 1);
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 6'h11, 1, 6'h22, 1);
`ifdef CUSTOM_LOGIC_RR_MERGE_BURST_EN
      exp_src = (k / BL) % 2;
`else
      exp_src = k % 2;
`endif
      chk("seq_src", o_ds, exp_src);
      chk("seq_valid", o_dv, 1);
      if (k == 7) begin
`ifdef CUSTOM_LOGIC_RR_MERGE_BURST_EN
        chk("seq_cnt_a", o_ca, 5);
        chk("seq_cnt_b", o_cb, 3);
`else
        chk("seq_cnt_a", o_ca, 4);
        chk("seq_cnt_b", o_cb, 4);
`endif
      end
    end

    // Consumer stall with both sides waiting, then release.
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 6'h11, 1, 6'h22, 0);
      chk("stall_ready_a", o_ra, 0);
      chk("stall_ready_b", o_rb, 0);
    end
    for (int k = 0; k < 3; k++) step(0, 1, 6'h13, 1, 6'h24, 1);

    // Lone B requester: streams every cycle and its counter wraps.
    step(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 18; k++) begin
      step(0, 0, 0, 1, DW'(k), 1);
      if (k > 0) chk("bonly_ready_b", o_rb, 1);
    end
    chk("wrap_cnt_b", o_cb, 1);
    chk("wrap_cnt_a", o_ca, 0);

    // Reset while a down beat is stalled.
    step(0, 1, 6'h07, 0, 0, 0);
    step(1, 1, 6'h07, 1, 6'h08, 0);
    chk("midrst_ready_a", o_ra, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_valid", o_dv, 0);
    chk("midrst_cnt_a", o_ca, 0);
    chk("midrst_cnt_b", o_cb, 0);
    step(0, 1, 6'h09, 1, 6'h0A, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("midrst_src", o_ds, 0);
    chk("midrst_data", o_dd, 6'h09);

    // Randomized traffic; sources hold their beat until it is accepted.
    va = 0; vb = 0; da = '0; db = '0; x_a = 1; x_b = 1;
    for (int k = 0; k < 600; k++) begin
      if (x_a || !va) begin va = ($urandom_range(3) != 0); da = DW'($urandom); end
      if (x_b || !vb) begin vb = ($urandom_range(3) != 0); db = DW'($urandom); end
      dr = ($urandom_range(3) != 0);
      step(($urandom_range(63) == 0), va, da, vb, db, dr);
      if (rst) begin va = 0; vb = 0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
